// File: rtl/recon_pkt_filter.sv
// Ingress frame classifier: steers recon frames and ordinary traffic to separate
// single-register output ports, drops runts, and counts frames per class.
module recon_pkt_filter #(
  parameter int          DATA_WIDTH     = 512,
  parameter int          KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter logic [15:0] RECON_UDP_PORT = 16'h4D52,
  parameter int          CNT_WIDTH      = 32
) (
  input  logic                  s_axis_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_recon_tdata,
  output logic [KEEP_WIDTH-1:0] m_recon_tkeep,
  output logic                  m_recon_tvalid,
  output logic                  m_recon_tlast,
  input  logic                  m_recon_tready,
  output logic [DATA_WIDTH-1:0] m_pass_tdata,
  output logic [KEEP_WIDTH-1:0] m_pass_tkeep,
  output logic                  m_pass_tvalid,
  output logic                  m_pass_tlast,
  input  logic                  m_pass_tready,
  output logic [CNT_WIDTH-1:0]  recon_frame_cnt,
  output logic [CNT_WIDTH-1:0]  pass_frame_cnt,
  output logic [CNT_WIDTH-1:0]  drop_frame_cnt
);

  typedef enum logic [1:0] {SOF, FWD_RECON, FWD_PASS, DROP} state_t;

  state_t state_q, state_d;
  state_t sof_target, target;

  logic                  recon_tvalid_q, recon_tlast_q;
  logic [DATA_WIDTH-1:0] recon_tdata_q;
  logic [KEEP_WIDTH-1:0] recon_tkeep_q;
  logic                  pass_tvalid_q, pass_tlast_q;
  logic [DATA_WIDTH-1:0] pass_tdata_q;
  logic [KEEP_WIDTH-1:0] pass_tkeep_q;
  logic [CNT_WIDTH-1:0]  recon_cnt_q, pass_cnt_q, drop_cnt_q;

  logic is_runt, is_recon;
  logic recon_loadable, pass_loadable;
  logic accept, load_recon, load_pass;

  // Header fields are in network byte order: the lower-numbered byte is the MSB.
  assign is_runt  = s_axis_tkeep[53:0] != {54{1'b1}};
  assign is_recon = !is_runt
                 && {s_axis_tdata[12*8 +: 8], s_axis_tdata[13*8 +: 8]} == 16'h0800
                 && s_axis_tdata[23*8 +: 8] == 8'h11
                 && {s_axis_tdata[36*8 +: 8], s_axis_tdata[37*8 +: 8]} == RECON_UDP_PORT;

  assign sof_target = is_runt ? DROP : (is_recon ? FWD_RECON : FWD_PASS);
  assign target     = (state_q == SOF) ? sof_target : state_q;

  assign recon_loadable = !recon_tvalid_q || m_recon_tready;
  assign pass_loadable  = !pass_tvalid_q  || m_pass_tready;

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign load_recon = accept && (target == FWD_RECON);
  assign load_pass  = accept && (target == FWD_PASS);

  always_ff @(posedge s_axis_clk) begin
    if (rst) state_q <= SOF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    case (target)
      FWD_RECON: s_axis_tready = recon_loadable;
      FWD_PASS:  s_axis_tready = pass_loadable;
      default:   s_axis_tready = 1'b1;
    endcase
    if (rst) s_axis_tready = 1'b0;
    if (accept) begin
      if (state_q == SOF) state_d = s_axis_tlast ? SOF : sof_target;
      else if (s_axis_tlast) state_d = SOF;
    end
  end

  always_ff @(posedge s_axis_clk) begin
    if (rst) begin
      recon_tvalid_q <= 1'b0;
      recon_tlast_q  <= 1'b0;
      recon_tdata_q  <= '0;
      recon_tkeep_q  <= '0;
    end else if (load_recon) begin
      recon_tvalid_q <= 1'b1;
      recon_tlast_q  <= s_axis_tlast;
      recon_tdata_q  <= s_axis_tdata;
      recon_tkeep_q  <= s_axis_tkeep;
    end else if (m_recon_tready) begin
      recon_tvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge s_axis_clk) begin
    if (rst) begin
      pass_tvalid_q <= 1'b0;
      pass_tlast_q  <= 1'b0;
      pass_tdata_q  <= '0;
      pass_tkeep_q  <= '0;
    end else if (load_pass) begin
      pass_tvalid_q <= 1'b1;
      pass_tlast_q  <= s_axis_tlast;
      pass_tdata_q  <= s_axis_tdata;
      pass_tkeep_q  <= s_axis_tkeep;
    end else if (m_pass_tready) begin
      pass_tvalid_q <= 1'b0;
    end
  end

  // A frame is counted on its accepted last beat, attributed to the class chosen at SOF.
  always_ff @(posedge s_axis_clk) begin
    if (rst) begin
      recon_cnt_q <= '0;
      pass_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else if (accept && s_axis_tlast) begin
      case (target)
        FWD_RECON: recon_cnt_q <= recon_cnt_q + CNT_WIDTH'(1);
        FWD_PASS:  pass_cnt_q  <= pass_cnt_q + CNT_WIDTH'(1);
        default:   drop_cnt_q  <= drop_cnt_q + CNT_WIDTH'(1);
      endcase
    end
  end

  assign m_recon_tdata   = recon_tdata_q;
  assign m_recon_tkeep   = recon_tkeep_q;
  assign m_recon_tvalid  = recon_tvalid_q;
  assign m_recon_tlast   = recon_tlast_q;
  assign m_pass_tdata    = pass_tdata_q;
  assign m_pass_tkeep    = pass_tkeep_q;
  assign m_pass_tvalid   = pass_tvalid_q;
  assign m_pass_tlast    = pass_tlast_q;
  assign recon_frame_cnt = recon_cnt_q;
  assign pass_frame_cnt  = pass_cnt_q;
  assign drop_frame_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_recon_pkt_filter.sv
// Scoreboard bench for recon_pkt_filter: expected beats are queued per port as they
// are accepted and compared when the corresponding output handshake occurs.
module tb_recon_pkt_filter;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int BUDGET = 60;
  localparam int D_RECON = 0, D_PASS = 1, D_DROP = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] r_tdata, p_tdata;
  logic [KW-1:0] r_tkeep, p_tkeep;
  logic          r_tvalid, r_tlast, r_tready;
  logic          p_tvalid, p_tlast, p_tready;
  logic [31:0]   r_cnt, p_cnt, d_cnt;

  beat_t rq[$];
  beat_t pq[$];
  int checks = 0;
  int failures = 0;
  int exp_r = 0, exp_p = 0, exp_d = 0;
  logic [DW-1:0] last_hdr;

  always #5 clk = ~clk;

  recon_pkt_filter dut (
    .s_axis_clk     (clk),
    .rst            (rst),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m_recon_tdata  (r_tdata),
    .m_recon_tkeep  (r_tkeep),
    .m_recon_tvalid (r_tvalid),
    .m_recon_tlast  (r_tlast),
    .m_recon_tready (r_tready),
    .m_pass_tdata   (p_tdata),
    .m_pass_tkeep   (p_tkeep),
    .m_pass_tvalid  (p_tvalid),
    .m_pass_tlast   (p_tlast),
    .m_pass_tready  (p_tready),
    .recon_frame_cnt(r_cnt),
    .pass_frame_cnt (p_cnt),
    .drop_frame_cnt (d_cnt)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] mk_hdr(input logic [15:0] etype, input logic [7:0] proto,
                                           input logic [15:0] port);
    logic [DW-1:0] d;
    d = rnd_data();
    d[12*8 +: 8] = etype[15:8];
    d[13*8 +: 8] = etype[7:0];
    d[23*8 +: 8] = proto;
    d[36*8 +: 8] = port[15:8];
    d[37*8 +: 8] = port[7:0];
    return d;
  endfunction

  // Output monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (r_tvalid && r_tready) begin
      if (rq.size() == 0) check("recon_unexpected_beat", 1, 0);
      else begin
        beat_t b;
        b = rq.pop_front();
        check("recon_data", r_tdata, b.d);
        check("recon_keep", DW'(r_tkeep), DW'(b.k));
        check("recon_last", DW'(r_tlast), DW'(b.l));
        $display("recon beat out last=%0b", r_tlast);
      end
    end
    if (p_tvalid && p_tready) begin
      if (pq.size() == 0) check("pass_unexpected_beat", 1, 0);
      else begin
        beat_t b;
        b = pq.pop_front();
        check("pass_data", p_tdata, b.d);
        check("pass_keep", DW'(p_tkeep), DW'(b.k));
        check("pass_last", DW'(p_tlast), DW'(b.l));
        $display("pass beat out last=%0b", p_tlast);
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input int dest, output int waits);
    beat_t b;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!s_tready && waits < BUDGET) begin
      waits++;
      @(negedge clk);
    end
    if (!s_tready) check("accept_timeout", 0, 1);
    else begin
      b.d = d; b.k = k; b.l = l;
      if (dest == D_RECON) rq.push_back(b);
      else if (dest == D_PASS) pq.push_back(b);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_recon_cnt"}, DW'(r_cnt), DW'(exp_r));
    check({tag, "_pass_cnt"},  DW'(p_cnt), DW'(exp_p));
    check({tag, "_drop_cnt"},  DW'(d_cnt), DW'(exp_d));
  endtask

  task automatic send_frame(input string tag, input logic [15:0] etype, input logic [7:0] proto,
                            input logic [15:0] port, input logic [KW-1:0] keep0,
                            input int nbeats, input int dest);
    int waits;
    for (int i = 0; i < nbeats; i++) begin
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      d = (i == 0) ? mk_hdr(etype, proto, port) : rnd_data();
      k = (i == 0) ? keep0 : {KW{1'b1}};
      if (i == 0) last_hdr = d;
      send_beat(d, k, i == nbeats - 1, dest, waits);
      if (dest == D_DROP) check({tag, "_drop_tready"}, DW'(waits), 0);
    end
    if (dest == D_RECON) exp_r++;
    else if (dest == D_PASS) exp_p++;
    else exp_d++;
    check_counters(tag);
    $display("frame %s sent beats=%0d dest=%0d", tag, nbeats, dest);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((rq.size() != 0 || pq.size() != 0) && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    check({tag, "_recon_q_empty"}, DW'(rq.size()), 0);
    check({tag, "_pass_q_empty"},  DW'(pq.size()), 0);
  endtask

  initial begin
    logic [KW-1:0] ones;
    int waits;
    ones     = {KW{1'b1}};
    rst      = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = '0;
    s_tkeep  = ones;
    s_tlast  = 1'b1;
    r_tready = 1'b1;
    p_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tready", DW'(s_tready), 0);
    check("rst_recon_valid", DW'(r_tvalid), 0);
    check("rst_pass_valid", DW'(p_tvalid), 0);
    check("rst_recon_data", r_tdata, 0);
    check_counters("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    s_tvalid = 1'b0;
    @(posedge clk); #1;

    // 1: single-beat recon frame
    send_frame("t1", 16'h0800, 8'h11, 16'h4D52, ones, 1, D_RECON);
    check("t1_valid_next", DW'(r_tvalid), 1);
    check("t1_data_next", r_tdata, last_hdr);
    drain("t1");

    // 2: three-beat recon frame with the sink stalled on beat 2
    r_tready = 1'b0;
    fork
      send_frame("t2", 16'h0800, 8'h11, 16'h4D52, ones, 3, D_RECON);
      begin
        int n = 0;
        @(negedge clk);
        while (!r_tvalid && n < 20) begin n++; @(negedge clk); end
        check("t2_first_beat_out", DW'(r_tvalid), 1);
        repeat (5) begin
          check("t2_stall_tready", DW'(s_tready), 0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        r_tready = 1'b1;
      end
    join
    drain("t2");

    // 3: IPv6 frame goes to pass
    send_frame("t3", 16'h86DD, 8'h11, 16'h4D52, ones, 2, D_PASS);
    drain("t3");

    // Near-miss headers: wrong protocol and wrong port go to pass
    send_frame("t3b", 16'h0800, 8'h06, 16'h4D52, ones, 1, D_PASS);
    send_frame("t3c", 16'h0800, 8'h11, 16'h4D53, ones, 2, D_PASS);
    drain("t3bc");

    // 4: runt frames are dropped with tready held high, including a one-byte-short keep
    send_frame("t4", 16'h0800, 8'h11, 16'h4D52, 64'h0000_0000_000F_FFFF, 4, D_DROP);
    send_frame("t4b", 16'h0800, 8'h11, 16'h4D52, 64'h001F_FFFF_FFFF_FFFF, 1, D_DROP);
    drain("t4");
    // Exactly 54 valid bytes is not a runt
    send_frame("t4c", 16'h0800, 8'h11, 16'h4D52, 64'h003F_FFFF_FFFF_FFFF, 1, D_RECON);
    drain("t4c");

    // 5: stalled recon stage must not block a pass frame
    r_tready = 1'b0;
    send_frame("t5r", 16'h0800, 8'h11, 16'h4D52, ones, 1, D_RECON);
    begin
      logic [DW-1:0] held;
      held = last_hdr;
      send_frame("t5p", 16'h1234, 8'h00, 16'h0000, ones, 2, D_PASS);
      repeat (2) @(posedge clk); #1;
      check("t5_pass_drained", DW'(pq.size()), 0);
      check("t5_recon_held_valid", DW'(r_tvalid), 1);
      check("t5_recon_held_data", r_tdata, held);
    end
    r_tready = 1'b1;
    drain("t5");

    // 6: reset in the middle of a recon frame
    begin
      logic [DW-1:0] d3;
      send_beat(mk_hdr(16'h0800, 8'h11, 16'h4D52), ones, 1'b0, D_RECON, waits);
      s_tdata  = rnd_data();
      s_tkeep  = ones;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      s_tvalid = 1'b0;
      rq.delete();
      pq.delete();
      exp_r = 0; exp_p = 0; exp_d = 0;
      check("t6_recon_valid", DW'(r_tvalid), 0);
      check("t6_pass_valid", DW'(p_tvalid), 0);
      check_counters("t6");
      d3 = rnd_data();
      d3[12*8 +: 8] = 8'h12;
      send_beat(d3, ones, 1'b1, D_PASS, waits);
      exp_p++;
      check_counters("t6_beat3");
      drain("t6");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
